mmio_io_bridge: RTL and testbench
=================================

Name: mmio_io_bridge

Overview:
- Memory-mapped I/O endpoint on the cpu's external bus, directly downstream of the cpu's mem_a/mem_dout/mem_wr outputs.
- Decodes accesses with mem_a[17:16]==2'b11. Buffers output bytes in a TX FIFO toward the UART transmitter and input bytes in an RX FIFO from the UART receiver.
- Maintains the cycle counter readable at 0x30004 and latches the program-stop condition.
- Produces io_buffer_full for the cpu and the I/O read byte that the board-level mux returns on mem_din.

Parameters:
- TX_DEPTH_LOG2, 4: log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG2, 4: log2 of RX FIFO depth (16 entries).
- FULL_MARGIN, 2: io_buffer_full asserts when free TX slots <= FULL_MARGIN. This covers the cpu's one-cycle write pipeline.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  cpu ready; cpu-side accesses are ignored when low.
- mem_a  in  32  cpu address bus.
- mem_dout  in  8  cpu write data.
- mem_wr  in  1  1 = write, 0 = read.
- io_sel  out  1  combinational: mem_a[17:16]==2'b11.
- io_din  out  8  registered read data, valid the cycle after a read address is presented.
- io_buffer_full  out  1  TX FIFO near full.
- tx_data  out  8  head byte of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  UART accepts tx_data this cycle.
- rx_data  in  8  received byte.
- rx_valid  in  1  push rx_data into the RX FIFO this cycle.
- rx_overflow  out  1  sticky: an rx byte was dropped because the RX FIFO was full.
- tx_overflow  out  1  sticky: a cpu write was dropped because the TX FIFO was full.
- prog_stop  out  1  sticky: a write to 0x30004 has been seen.

Behaviour:
- Reset (rst_in low, asynchronous): all outputs and state clear.
  - io_din=0, both FIFOs empty, tx_valid=0, io_buffer_full=0.
  - cycle counter=0, snapshot=0, all sticky flags=0.
- A cpu access counts only when rdy_in=1 and io_sel=1. Address offset is mem_a[2:0].
- Cycle counter: 32-bit, increments every clk_in regardless of rdy_in, wraps 0xFFFFFFFF->0.
- Write to offset 0 with mem_dout != 0: push mem_dout into the TX FIFO.
  - If the FIFO is full, drop the byte and set tx_overflow.
  - Writes of 0x00 are ignored.
- Write to offset 4: set prog_stop and push 0x00 into the TX FIFO. This push bypasses the zero filter; if the FIFO is full, set tx_overflow.
  - After prog_stop=1, all further cpu writes are ignored. Reads still work.
- Read at offset 0: next cycle io_din = RX head, and the entry is popped.
  - If the RX FIFO is empty, io_din=0x00 and nothing is popped.
- Read at offset 4: snapshot <= current counter value; next cycle io_din = counter[7:0].
- Read at offsets 5/6/7: io_din = snapshot byte 1/2/3 (bits 8k+7:8k for offset 4+k). The snapshot is not updated, so the 4-byte read is coherent.
- Any other I/O read: io_din=0x00.
- Non-I/O cycles and rdy_in=0: io_din holds its value.
- TX drain: when tx_valid && tx_ready, pop the head. A pop and a push in the same cycle leave the count unchanged; this works even when the FIFO is full, where the push is accepted.
- RX fill: when rx_valid, push rx_data. If full, drop and set rx_overflow.
  - A cpu pop and an rx push in the same cycle are both performed, including when the FIFO is full.
- io_buffer_full = (TX count >= 2^TX_DEPTH_LOG2 - FULL_MARGIN), derived from the registered count.
- FIFOs are circular with pointers one bit wider than the index; full and empty are decided by pointer MSB comparison, so wrap-around needs no special case.
- The UART side (tx drain, rx fill) and the counter keep running while rdy_in=0.

Test Plan:
- Reset, then write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=0 -> TX count=2. Raising tx_ready yields tx_data 0x41 then 0x42, then tx_valid=0.
- With tx_ready=0, write 14 nonzero bytes -> io_buffer_full=1 once the count reaches 14. Writes 17 and 18 (after 16 stored) set tx_overflow and the count stays 16.
- Push rx bytes 0x10, 0x20, then read 0x30000 three times -> io_din is 0x10, 0x20, 0x00 on the cycles after each read.
- Hold reset release, run 300 cycles, read 0x30004..0x30007 -> the bytes reassemble to the snapshot value, even though the counter advances during the 4 reads. Counter preloaded at 0xFFFFFFFF wraps to 0.
- Write 0x30004 -> prog_stop=1 and 0x00 appears on tx_data. A subsequent write of 0x55 to 0x30000 produces no TX push.
- With rdy_in=0, apply a write and a read to 0x30000 -> no FIFO change and io_din unchanged. Meanwhile an asynchronous rst_in low mid-drain empties both FIFOs immediately.

Source files
------------

// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge: memory-mapped I/O endpoint on the cpu external bus.
// Decodes mem_a[17:16]==2'b11, buffers cpu output bytes toward the UART
// transmitter, buffers received bytes for cpu reads, keeps a free-running
// cycle counter with a coherent 4-byte snapshot, and latches program stop.
//
// Handshake: tx_valid/tx_ready and rx_valid follow strict valid/ready rules.
// A byte moves on tx only in a cycle where tx_valid && tx_ready at the clock
// edge; tx_data is stable while tx_valid is high and tx_ready is low.
// rx_valid has no back-pressure: a byte offered while the RX FIFO is full
// (and not being popped in the same cycle) is dropped and flagged.
module mmio_io_bridge #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic        io_sel,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_overflow,
    output logic        tx_overflow,
    output logic        prog_stop
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL_LEVEL =
        (TX_DEPTH_LOG2 + 1)'(TX_DEPTH - FULL_MARGIN);

    // Address decode; only the select bits and the byte offset matter.
    logic [2:0] offset;
    logic       cpu_acc;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       unused_addr_bits;

    assign io_sel           = (mem_a[17:16] == 2'b11);
    assign offset           = mem_a[2:0];
    assign cpu_acc          = rdy_in && io_sel;
    assign cpu_wr           = cpu_acc && mem_wr && !prog_stop;
    assign cpu_rd           = cpu_acc && !mem_wr;
    assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

    // TX FIFO: pointers one bit wider than the index so full/empty fall out
    // of the MSB comparison without wrap special cases.
    logic [TX_DEPTH_LOG2:0] tx_wptr;
    logic [TX_DEPTH_LOG2:0] tx_rptr;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [7:0]             tx_mem [TX_DEPTH];
    logic                   tx_empty;
    logic                   tx_full;
    logic                   tx_pop;
    logic                   tx_push_req;
    logic                   tx_push;
    logic [7:0]             tx_push_data;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_DEPTH_LOG2] != tx_rptr[TX_DEPTH_LOG2]) &&
                      (tx_wptr[TX_DEPTH_LOG2-1:0] == tx_rptr[TX_DEPTH_LOG2-1:0]);
    assign tx_count = tx_wptr - tx_rptr;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];
    assign tx_pop   = tx_valid && tx_ready;

    // Offset 4 pushes a 0x00 terminator that bypasses the zero filter.
    assign tx_push_req  = cpu_wr && (((offset == 3'd0) && (mem_dout != 8'h00)) ||
                                     (offset == 3'd4));
    assign tx_push_data = (offset == 3'd4) ? 8'h00 : mem_dout;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign tx_push      = tx_push_req && (!tx_full || tx_pop);

    assign io_buffer_full = (tx_count >= TX_FULL_LEVEL);

    // TX storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wptr[TX_DEPTH_LOG2-1:0]] <= tx_push_data;
    end

    // TX pointer update.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        end
    end

    // RX FIFO, same pointer scheme as TX.
    logic [RX_DEPTH_LOG2:0] rx_wptr;
    logic [RX_DEPTH_LOG2:0] rx_rptr;
    logic [7:0]             rx_mem [RX_DEPTH];
    logic [7:0]             rx_head;
    logic                   rx_empty;
    logic                   rx_full;
    logic                   rx_pop;
    logic                   rx_push;

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[RX_DEPTH_LOG2] != rx_rptr[RX_DEPTH_LOG2]) &&
                      (rx_wptr[RX_DEPTH_LOG2-1:0] == rx_rptr[RX_DEPTH_LOG2-1:0]);
    assign rx_head  = rx_mem[rx_rptr[RX_DEPTH_LOG2-1:0]];
    assign rx_pop   = cpu_rd && (offset == 3'd0) && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);

    // RX storage write.
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
    end

    // RX pointer update.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // Cycle counter and upper snapshot bytes; byte 0 is returned live at
    // offset 4, so only bytes 1..3 need holding for the coherent read.
    logic [31:0] cycle_cnt;
    logic [23:0] snap_hi;
    logic [7:0]  rd_data;
    logic        snap_load;

    // Read-data select for the I/O register window.
    always_comb begin
        rd_data   = 8'h00;
        snap_load = 1'b0;
        case (offset)
            3'd0:    rd_data = rx_empty ? 8'h00 : rx_head;
            3'd4: begin
                rd_data   = cycle_cnt[7:0];
                snap_load = 1'b1;
            end
            3'd5:    rd_data = snap_hi[7:0];
            3'd6:    rd_data = snap_hi[15:8];
            3'd7:    rd_data = snap_hi[23:16];
            default: rd_data = 8'h00;
        endcase
    end

    // Free-running counter, independent of rdy_in.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 32'd1;
    end

    // Registered read data and snapshot; both hold outside accepted reads.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_din  <= 8'h00;
            snap_hi <= '0;
        end else if (cpu_rd) begin
            io_din <= rd_data;
            if (snap_load) snap_hi <= cycle_cnt[31:8];
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_overflow <= 1'b0;
            rx_overflow <= 1'b0;
            prog_stop   <= 1'b0;
        end else begin
            if (tx_push_req && !tx_push)            tx_overflow <= 1'b1;
            if (rx_valid && !rx_push)               rx_overflow <= 1'b1;
            if (cpu_wr && (offset == 3'd4))         prog_stop   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mmio_io_bridge.sv
// Testbench for mmio_io_bridge: queue-based reference model updated at each
// active edge, expected read data pushed into a scoreboard queue and checked
// by a separate monitor on the opposite edge.
module tb_mmio_io_bridge;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    // Clock / reset and DUT signals
    logic        clk_in   = 1'b0;
    logic        rst_in   = 1'b0;
    logic        rdy_in   = 1'b1;
    logic [31:0] mem_a    = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr   = 1'b0;
    logic        io_sel;
    logic [7:0]  io_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic        rx_overflow;
    logic        tx_overflow;
    logic        prog_stop;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_tx_q[$];
    logic [7:0]  m_rx_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] m_cnt    = '0;
    logic [31:0] m_snap   = '0;
    logic        m_tx_ovf = 1'b0;
    logic        m_rx_ovf = 1'b0;
    logic        m_stop   = 1'b0;
    logic [7:0]  m_din    = '0;
    logic        m_acc;
    logic [2:0]  m_off;
    logic [7:0]  m_rd;
    logic [7:0]  rb[4];

    mmio_io_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .io_sel         (io_sel),
        .io_din         (io_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_overflow    (rx_overflow),
        .tx_overflow    (tx_overflow),
        .prog_stop      (prog_stop)
    );

    // Clock generation
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per active edge, FIFOs as queues.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_tx_q.delete();
            m_rx_q.delete();
            exp_q.delete();
            m_cnt    = '0;
            m_snap   = '0;
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
            m_stop   = 1'b0;
            m_din    = '0;
        end else begin
            check("io_sel", io_sel, mem_a[17:16] == 2'b11);
            m_acc = rdy_in && (mem_a[17:16] == 2'b11);
            m_off = mem_a[2:0];
            // UART drain uses the occupancy before this edge
            if (tx_ready && m_tx_q.size() != 0) begin
                check("tx_data_drained", tx_data, m_tx_q[0]);
                void'(m_tx_q.pop_front());
            end
            if (m_acc && mem_wr && !m_stop) begin
                if (m_off == 3'd4) begin
                    m_stop = 1'b1;
                    if (m_tx_q.size() < DEPTH) m_tx_q.push_back(8'h00);
                    else m_tx_ovf = 1'b1;
                end else if (m_off == 3'd0 && mem_dout != 8'h00) begin
                    if (m_tx_q.size() < DEPTH) m_tx_q.push_back(mem_dout);
                    else m_tx_ovf = 1'b1;
                end
            end
            if (m_acc && !mem_wr) begin
                m_rd = 8'h00;
                case (m_off)
                    3'd0: if (m_rx_q.size() != 0) m_rd = m_rx_q.pop_front();
                    3'd4: begin
                        m_snap = m_cnt;
                        m_rd   = m_cnt[7:0];
                    end
                    3'd5: m_rd = m_snap[15:8];
                    3'd6: m_rd = m_snap[23:16];
                    3'd7: m_rd = m_snap[31:24];
                    default: m_rd = 8'h00;
                endcase
                exp_q.push_back(m_rd);
            end
            if (rx_valid) begin
                if (m_rx_q.size() < DEPTH) m_rx_q.push_back(rx_data);
                else m_rx_ovf = 1'b1;
            end
            m_cnt = m_cnt + 32'd1;
        end
    end

    // Monitor: compares outputs on the inactive edge.
    always @(negedge clk_in) begin
        if (exp_q.size() != 0) m_din = exp_q.pop_front();
        check("io_din", io_din, m_din);
        check("tx_valid", tx_valid, m_tx_q.size() != 0);
        if (m_tx_q.size() != 0) check("tx_data_head", tx_data, m_tx_q[0]);
        check("io_buffer_full", io_buffer_full, m_tx_q.size() >= DEPTH - MARGIN);
        check("tx_overflow", tx_overflow, m_tx_ovf);
        check("rx_overflow", rx_overflow, m_rx_ovf);
        check("prog_stop", prog_stop, m_stop);
    end

    // Driver tasks
    task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [7:0] d);
        @(negedge clk_in);
        mem_wr   = wr;
        mem_a    = addr;
        mem_dout = d;
    endtask

    task automatic cpu_idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            mem_wr   = 1'b0;
            mem_a    = '0;
            mem_dout = '0;
        end
    endtask

    task automatic wait_tx_empty(input int budget);
        int n = 0;
        while ((m_tx_q.size() != 0 || tx_valid) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (m_tx_q.size() != 0 || tx_valid) begin
            errors++;
            $display("FAIL tx_drain_timeout: tx_valid=%0b model_count=%0d expected 0", tx_valid, m_tx_q.size());
        end
    endtask

    task automatic rx_burst(input int n);
        repeat (n) begin
            @(negedge clk_in);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [31:0] a;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;

        // zero filter and in-order drain
        tx_ready = 1'b0;
        cpu_op(1'b1, 32'h0003_0000, 8'h41);
        cpu_op(1'b1, 32'h0003_0000, 8'h00);
        cpu_op(1'b1, 32'h0003_0000, 8'h42);
        cpu_idle(2);
        tx_ready = 1'b1;
        wait_tx_empty(20);
        tx_ready = 1'b0;

        // near-full threshold and TX overflow
        for (int i = 0; i < 18; i++) cpu_op(1'b1, 32'h0003_0000, 8'(i + 1));
        cpu_idle(1);
        check("tx_overflow_after_18", tx_overflow, 1'b1);
        check("buffer_full_at_16", io_buffer_full, 1'b1);
        tx_ready = 1'b1;
        // push into a full FIFO while it drains
        cpu_op(1'b1, 32'h0003_0000, 8'h99);
        cpu_idle(1);
        wait_tx_empty(40);
        tx_ready = 1'b0;

        // RX reads including empty
        @(negedge clk_in); rx_valid = 1'b1; rx_data = 8'h10;
        @(negedge clk_in); rx_data = 8'h20;
        @(negedge clk_in); rx_valid = 1'b0;
        repeat (3) cpu_op(1'b0, 32'h0003_0000, 8'h00);
        cpu_idle(2);

        // coherent 4-byte counter read
        cpu_idle(300);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            if (k > 0) rb[k-1] = io_din;
            mem_wr = 1'b0;
            mem_a  = (k < 4) ? 32'h0003_0004 + 32'(k) : 32'h0;
        end
        check("snapshot_coherent", {rb[3], rb[2], rb[1], rb[0]}, m_snap);

        // RX overflow then drain by reads, with one rx push during a pop of a full FIFO
        rx_burst(18);
        @(negedge clk_in);
        mem_wr = 1'b0; mem_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h5A;
        @(negedge clk_in);
        rx_valid = 1'b0;
        repeat (17) cpu_op(1'b0, 32'h0003_0000, 8'h00);
        cpu_idle(2);

        // rdy_in low: cpu accesses ignored
        rx_burst(1);
        rdy_in = 1'b0;
        cpu_op(1'b1, 32'h0003_0000, 8'h77);
        cpu_op(1'b0, 32'h0003_0000, 8'h00);
        cpu_idle(2);
        check("rdy_low_no_push", tx_valid, 1'b0);
        rdy_in = 1'b1;
        cpu_op(1'b0, 32'h0003_0000, 8'h00);
        cpu_idle(2);

        // randomized traffic (no stop writes)
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_in);
            rdy_in   = ($urandom_range(0, 3) != 0);
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                if (a[17:16] == 2'b11) a[17] = 1'b0;
            end else begin
                a = 32'h0003_0000 | 32'($urandom_range(0, 7));
            end
            mem_wr = ($urandom_range(0, 1) == 1);
            if (mem_wr && a[17:16] == 2'b11 && a[2:0] == 3'd4) a[2:0] = 3'd0;
            mem_a    = a;
            mem_dout = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        cpu_idle(1);
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_tx_empty(40);

        // asynchronous reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) cpu_op(1'b1, 32'h0003_0000, 8'hC0 + 8'(i));
        cpu_idle(1);
        rx_burst(3);
        tx_ready = 1'b1;
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        check("async_rst_tx_valid", tx_valid, 1'b0);
        check("async_rst_buffer_full", io_buffer_full, 1'b0);
        check("async_rst_io_din", io_din, 8'h00);
        check("async_rst_tx_overflow", tx_overflow, 1'b0);
        check("async_rst_rx_overflow", rx_overflow, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in   = 1'b1;
        tx_ready = 1'b0;
        cpu_op(1'b0, 32'h0003_0000, 8'h00);
        cpu_idle(2);

        // program stop: terminator pushed, later writes ignored, reads work
        tx_ready = 1'b1;
        cpu_op(1'b1, 32'h0003_0004, 8'hAB);
        cpu_op(1'b1, 32'h0003_0000, 8'h55);
        cpu_op(1'b1, 32'h0003_0004, 8'h00);
        cpu_idle(2);
        check("prog_stop_set", prog_stop, 1'b1);
        wait_tx_empty(20);
        rx_burst(1);
        cpu_op(1'b0, 32'h0003_0000, 8'h00);
        cpu_idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
